// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and frame/counter sizing helpers for piso_serializer
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Bits per frame: data bits, plus one trailing parity bit when enabled.
    function automatic int piso_frame(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Counter must be able to hold the value FRAME itself.
    function automatic int piso_cnt_w(input int width);
        return $clog2(piso_frame(width) + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// rtl/piso_bit_counter.sv - counts frame bits already driven, flags the last and next-to-last bit
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic step_i,
    input  logic clear_i,
    output logic last_o,
    output logic pre_last_o
);

    localparam int FRAME = piso_frame(WIDTH);
    localparam int CW    = piso_cnt_w(WIDTH);

    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(FRAME);
    localparam logic [CW-1:0] CNT_PRELAST = CW'(FRAME - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: a start means the first bit goes out now, so the count begins at one.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CNT_ONE;
        end else if (clear_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o     = (cnt_q == CNT_LAST);
    assign pre_last_o = (cnt_q == CNT_PRELAST);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - LSB-first parallel-in/serial-out transmitter (option: PISO_SERIALIZER_PARITY_EN)
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic             last;
    logic             pre_last;
    logic             accept;
    logic             step;
    logic             clear;
    logic [WIDTH-1:0] load_word;

    // The parity bit rides in the vacated MSB of the shift register, so it
    // falls out naturally right after data bit WIDTH-1.
`ifdef PISO_SERIALIZER_PARITY_EN
    assign load_word = {^din, din[WIDTH-1:1]};
`else
    assign load_word = {1'b0, din[WIDTH-1:1]};
`endif

    assign ready  = (state_q == IDLE) || last;
    assign accept = load && ready;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .start_i   (accept),
        .step_i    (step),
        .clear_i   (clear),
        .last_o    (last),
        .pre_last_o(pre_last)
    );

    // Next-state: load (also on the last-bit cycle for gapless frames), shift, or drop to idle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        valid_d = valid_q;
        done_d  = done_q;
        step    = 1'b0;
        clear   = 1'b0;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = load_word;
            sout_d  = din[0];
            valid_d = 1'b1;
            done_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last) begin
                state_d = IDLE;
                shreg_d = '0;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                done_d  = 1'b0;
                clear   = 1'b1;
            end else begin
                shreg_d = shreg_q >> 1;
                sout_d  = shreg_q[0];
                done_d  = pre_last;
                step    = 1'b1;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign done       = done_q;

endmodule
